hyper_burst_splitter: RTL and testbench
=======================================

Name: hyper_burst_splitter

Overview:
- Parametrised transfer splitter between the AXI-side transfer generator and the HyperBus PHY.
- Takes one transfer descriptor: write flag, burst length in PHY words, burst type, address space and byte address.
- Emits a sequence of sub-transfers, each no longer than the configured maximum burst.
- Generalises the single-PHY transfer type to NumPhys parallel PHYs; word size is 16*NumPhys bits.

Parameters:
- NumPhys, 1: number of parallel PHYs, legal values 1 or 2; one word is 2*NumPhys bytes.
- AddrWidth, 32: byte-address width.
- BurstWidth, 15: width of burst-length fields, in words.
- MaxWidth, 16: width of the configured maximum-burst field.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_burst_max_i  in  MaxWidth  max words per sub-transfer; 0 = unlimited.
- in_valid_i  in  1  descriptor valid.
- in_ready_o  out  1  descriptor accepted when valid&&ready.
- in_write_i  in  1  transfer is a write.
- in_burst_i  in  BurstWidth  total length in words.
- in_burst_type_i  in  1  1 = linear, 0 = wrapped.
- in_addr_space_i  in  1  1 = register space, 0 = memory.
- in_addr_i  in  AddrWidth  start byte address.
- out_valid_o  out  1  sub-transfer valid.
- out_ready_i  in  1  PHY accepts sub-transfer.
- out_write_o  out  1  copy of latched write flag.
- out_burst_o  out  BurstWidth  sub-transfer length in words.
- out_burst_type_o  out  1  copy of latched burst type.
- out_addr_space_o  out  1  copy of latched address space.
- out_addr_o  out  AddrWidth  sub-transfer start byte address.
- out_first_o  out  1  first sub-transfer of the descriptor.
- out_last_o  out  1  final sub-transfer of the descriptor.
- busy_o  out  1  descriptor in progress.

Behaviour:
- One clock domain; rst_ni is asynchronous assert, synchronous deassert (synchroniser external).
- Reset values: in_ready_o=1; out_valid_o=0; all out_* payload fields 0; busy_o=0; state=Idle.
- Two states:
  - Idle: in_ready_o=1, out_valid_o=0. On in_valid_i&&in_ready_o, latch the descriptor and cfg_burst_max_i into registers (cfg changes mid-transfer are ignored), set rem=in_burst_i, addr=in_addr_i, first=1, then go to Emit.
  - Emit: in_ready_o=0, out_valid_o=1, busy_o=1.
- Latency: out_valid_o rises the cycle after input acceptance. No fall-through.
- Chunk rule, in Emit:
  - If burst_max==0, or burst_type==0 (wrapped), or rem<=burst_max: chunk=rem and last=1.
  - Otherwise: chunk=burst_max and last=0.
  - Compare after zero-extending both operands to max(BurstWidth,MaxWidth).
  - out_burst_o=chunk; out_last_o=last; out_first_o=first.
- On out_valid_o&&out_ready_i:
  - If last: go to Idle.
  - Else: rem -= chunk; addr += chunk*2*NumPhys, modulo 2^AddrWidth (address wraps silently); first=0.
- Output stability: while out_valid_o&&!out_ready_i, all out_* fields are held stable and out_valid_o does not drop.
- Throughput: in_ready_o is low for the whole Emit phase. There is one Idle cycle between the last output handshake and the next input acceptance; the same-cycle overlap path is deliberately omitted.
- Boundaries:
  - in_burst_i==0: forwarded as a single sub-transfer with out_burst_o=0, first=1, last=1.
  - rem equal to burst_max: a single final chunk with last=1, never a trailing zero-length chunk.
  - Wrapped bursts are never split, whatever burst_max is.
- Reset mid-transfer: all state cleared immediately, remaining sub-transfers are discarded, out_valid_o=0 asynchronously.

Test Plan:
- NumPhys=1, max=4, linear, burst=10, addr=0x100 -> three outputs (0x100,4,first), (0x108,4), (0x110,2,last); in_ready_o low throughout, high one cycle after the last handshake.
- NumPhys=2, same stimulus -> (0x100,4), (0x110,4), (0x120,2,last).
- Wrapped burst=10, max=4 -> one output (0x100,10, first=last=1). Linear burst=10, max=0 -> one output of burst 10.
- NumPhys=1, max=4, burst=8, addr=0xFFFF_FFF8 -> (0xFFFF_FFF8,4), (0x0000_0000,4,last).
- Hold out_ready_i=0 for 5 cycles during the second chunk -> payload and out_valid_o constant; change cfg_burst_max_i mid-transfer -> chunk sizes unaffected.
- Assert rst_ni low after the first handshake of a 3-chunk transfer -> out_valid_o=0 immediately; after release, in_ready_o=1 and no stale chunks are emitted.

Source files
------------

// File: rtl/hyper_burst_splitter.sv
// hyper_burst_splitter: cuts one transfer descriptor into sub-transfers of at
// most cfg_burst_max_i words for NumPhys parallel HyperBus PHYs.
//
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   cfg_burst_max_i         max words per sub-transfer (0 = unlimited)
//   in_*  (valid/ready)     descriptor: write, burst, burst_type, addr_space, addr
//   out_* (valid/ready)     sub-transfer: same fields plus first/last markers
//   busy_o                  a descriptor is being emitted
module hyper_burst_splitter #(
    parameter int unsigned NumPhys    = 1,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned BurstWidth = 15,
    parameter int unsigned MaxWidth   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [MaxWidth-1:0]   cfg_burst_max_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  in_write_i,
    input  logic [BurstWidth-1:0] in_burst_i,
    input  logic                  in_burst_type_i,
    input  logic                  in_addr_space_i,
    input  logic [AddrWidth-1:0]  in_addr_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_write_o,
    output logic [BurstWidth-1:0] out_burst_o,
    output logic                  out_burst_type_o,
    output logic                  out_addr_space_o,
    output logic [AddrWidth-1:0]  out_addr_o,
    output logic                  out_first_o,
    output logic                  out_last_o,
    output logic                  busy_o
);

    localparam int unsigned CmpWidth =
        (BurstWidth > MaxWidth) ? BurstWidth : MaxWidth;

    typedef enum logic {
        Idle,
        Emit
    } state_e;

    state_e                state_q;
    logic [MaxWidth-1:0]   max_q;
    logic [BurstWidth-1:0] rem_q;

    logic [BurstWidth-1:0] nxt_rem;
    logic [AddrWidth-1:0]  nxt_addr;
    logic [BurstWidth-1:0] sel_rem;
    logic [MaxWidth-1:0]   sel_max;
    logic                  sel_linear;
    logic [CmpWidth-1:0]   rem_ext;
    logic [CmpWidth-1:0]   max_ext;
    logic                  split;
    logic [BurstWidth-1:0] chunk;

    // rem_q holds the words left including the chunk currently presented
    assign nxt_rem  = rem_q - out_burst_o;
    assign nxt_addr = out_addr_o
                    + AddrWidth'(out_burst_o) * AddrWidth'(2 * NumPhys);

    // Chunk for the sub-transfer about to be loaded into the output
    // registers: from the inputs on acceptance, from the latched
    // descriptor when advancing.
    always_comb begin
        sel_rem    = nxt_rem;
        sel_max    = max_q;
        sel_linear = out_burst_type_o;
        if (state_q == Idle) begin
            sel_rem    = in_burst_i;
            sel_max    = cfg_burst_max_i;
            sel_linear = in_burst_type_i;
        end
        rem_ext = CmpWidth'(sel_rem);
        max_ext = CmpWidth'(sel_max);
        split   = (sel_max != '0) && sel_linear && (rem_ext > max_ext);
        // when split, max < rem so it fits in BurstWidth
        chunk   = split ? BurstWidth'(max_ext) : sel_rem;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= Idle;
            max_q            <= '0;
            rem_q            <= '0;
            in_ready_o       <= 1'b1;
            out_valid_o      <= 1'b0;
            out_write_o      <= 1'b0;
            out_burst_o      <= '0;
            out_burst_type_o <= 1'b0;
            out_addr_space_o <= 1'b0;
            out_addr_o       <= '0;
            out_first_o      <= 1'b0;
            out_last_o       <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            case (state_q)
                Idle: begin
                    if (in_valid_i) begin
                        state_q          <= Emit;
                        max_q            <= cfg_burst_max_i;
                        rem_q            <= in_burst_i;
                        in_ready_o       <= 1'b0;
                        out_valid_o      <= 1'b1;
                        busy_o           <= 1'b1;
                        out_write_o      <= in_write_i;
                        out_burst_type_o <= in_burst_type_i;
                        out_addr_space_o <= in_addr_space_i;
                        out_addr_o       <= in_addr_i;
                        out_burst_o      <= chunk;
                        out_first_o      <= 1'b1;
                        out_last_o       <= !split;
                    end
                end
                Emit: begin
                    if (out_ready_i) begin
                        if (out_last_o) begin
                            state_q     <= Idle;
                            in_ready_o  <= 1'b1;
                            out_valid_o <= 1'b0;
                            busy_o      <= 1'b0;
                        end else begin
                            rem_q       <= nxt_rem;
                            out_addr_o  <= nxt_addr;
                            out_burst_o <= chunk;
                            out_first_o <= 1'b0;
                            out_last_o  <= !split;
                        end
                    end
                end
                default: state_q <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_hyper_burst_splitter.sv
// tb_hyper_burst_splitter: directed and random descriptors driven into a
// NumPhys=1 and a NumPhys=2 instance in lockstep, checked against a model.
module tb_hyper_burst_splitter;

    localparam int AW = 32;
    localparam int BW = 15;
    localparam int MW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [MW-1:0] cfg_max = '0;
    logic          in_valid = 1'b0;
    logic          in_write = 1'b0;
    logic [BW-1:0] in_burst = '0;
    logic          in_type = 1'b0;
    logic          in_space = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic          out_ready = 1'b0;

    logic          in_rdy [2];
    logic          ov     [2];
    logic          ow     [2];
    logic [BW-1:0] ob     [2];
    logic          ot     [2];
    logic          os     [2];
    logic [AW-1:0] oa     [2];
    logic          of     [2];
    logic          ol     [2];
    logic          busy   [2];

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    hyper_burst_splitter #(.NumPhys(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .cfg_burst_max_i(cfg_max),
        .in_valid_i(in_valid), .in_ready_o(in_rdy[0]),
        .in_write_i(in_write), .in_burst_i(in_burst),
        .in_burst_type_i(in_type), .in_addr_space_i(in_space),
        .in_addr_i(in_addr), .out_valid_o(ov[0]), .out_ready_i(out_ready),
        .out_write_o(ow[0]), .out_burst_o(ob[0]), .out_burst_type_o(ot[0]),
        .out_addr_space_o(os[0]), .out_addr_o(oa[0]), .out_first_o(of[0]),
        .out_last_o(ol[0]), .busy_o(busy[0])
    );

    hyper_burst_splitter #(.NumPhys(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .cfg_burst_max_i(cfg_max),
        .in_valid_i(in_valid), .in_ready_o(in_rdy[1]),
        .in_write_i(in_write), .in_burst_i(in_burst),
        .in_burst_type_i(in_type), .in_addr_space_i(in_space),
        .in_addr_i(in_addr), .out_valid_o(ov[1]), .out_ready_i(out_ready),
        .out_write_o(ow[1]), .out_burst_o(ob[1]), .out_burst_type_o(ot[1]),
        .out_addr_space_o(os[1]), .out_addr_o(oa[1]), .out_first_o(of[1]),
        .out_last_o(ol[1]), .busy_o(busy[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s.p%0d.in_ready", tag, d + 1), 64'(in_rdy[d]), 1);
            chk($sformatf("%s.p%0d.valid", tag, d + 1), 64'(ov[d]), 0);
            chk($sformatf("%s.p%0d.busy", tag, d + 1), 64'(busy[d]), 0);
        end
    endtask

    // Expected sub-transfer k of n: chunks of max words, the remainder last.
    task automatic check_chunk(input string tag, input int unsigned k,
                               input int unsigned n, input int unsigned sz,
                               input int unsigned max, input logic [AW-1:0] addr,
                               input bit wr, input bit lin, input bit sp);
        logic [AW-1:0] ea;
        for (int d = 0; d < 2; d++) begin
            ea = addr + AW'(k * max * 2 * (d + 1));
            chk($sformatf("%s.c%0d.p%0d.valid", tag, k, d + 1), 64'(ov[d]), 1);
            chk($sformatf("%s.c%0d.p%0d.in_ready", tag, k, d + 1), 64'(in_rdy[d]), 0);
            chk($sformatf("%s.c%0d.p%0d.busy", tag, k, d + 1), 64'(busy[d]), 1);
            chk($sformatf("%s.c%0d.p%0d.burst", tag, k, d + 1), 64'(ob[d]), 64'(sz));
            chk($sformatf("%s.c%0d.p%0d.addr", tag, k, d + 1), 64'(oa[d]), 64'(ea));
            chk($sformatf("%s.c%0d.p%0d.first", tag, k, d + 1), 64'(of[d]), 64'(k == 0));
            chk($sformatf("%s.c%0d.p%0d.last", tag, k, d + 1), 64'(ol[d]), 64'(k == n - 1));
            chk($sformatf("%s.c%0d.p%0d.write", tag, k, d + 1), 64'(ow[d]), 64'(wr));
            chk($sformatf("%s.c%0d.p%0d.type", tag, k, d + 1), 64'(ot[d]), 64'(lin));
            chk($sformatf("%s.c%0d.p%0d.space", tag, k, d + 1), 64'(os[d]), 64'(sp));
        end
    endtask

    // Called at a negedge while the DUTs are idle; returns at the negedge
    // right after the last output handshake.
    task automatic xfer(input string tag, input bit wr, input int unsigned burst,
                        input bit lin, input bit sp, input logic [AW-1:0] addr,
                        input int unsigned max, input int stall_k,
                        input int stall_n, input bit rnd);
        int unsigned n;
        int unsigned sz;
        int stalls;
        cfg_max  = MW'(max);
        in_valid = 1'b1;
        in_write = wr;
        in_burst = BW'(burst);
        in_type  = lin;
        in_space = sp;
        in_addr  = addr;
        @(negedge clk);
        // scramble inputs: the DUT must work from what it latched
        in_valid = 1'b0;
        in_write = 1'($urandom);
        in_burst = BW'($urandom);
        in_type  = 1'($urandom);
        in_space = 1'($urandom);
        in_addr  = $urandom;
        cfg_max  = MW'($urandom_range(0, 9));
        if (lin && max != 0 && burst > max) n = (burst + max - 1) / max;
        else n = 1;
        for (int unsigned k = 0; k < n; k++) begin
            if (n == 1) sz = burst;
            else if (k < n - 1) sz = max;
            else sz = burst - (n - 1) * max;
            if (int'(k) == stall_k) stalls = stall_n;
            else if (rnd) stalls = int'($urandom_range(0, 2));
            else stalls = 0;
            for (int s = 0; s <= stalls; s++) begin
                out_ready = (s == stalls);
                check_chunk(tag, k, n, sz, max, addr, wr, lin, sp);
                @(negedge clk);
            end
        end
        out_ready = 1'b0;
        check_idle({tag, ".done"});
    endtask

    initial begin
        @(negedge clk);
        check_idle("reset");
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset.p%0d.burst", d + 1), 64'(ob[d]), 0);
            chk($sformatf("reset.p%0d.addr", d + 1), 64'(oa[d]), 0);
            chk($sformatf("reset.p%0d.first", d + 1), 64'(of[d]), 0);
            chk($sformatf("reset.p%0d.last", d + 1), 64'(ol[d]), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("released");

        xfer("lin10", 1, 10, 1, 0, 32'h100, 4, -1, 0, 0);
        xfer("wrap10", 0, 10, 0, 1, 32'h100, 4, -1, 0, 0);
        xfer("nomax", 1, 10, 1, 0, 32'h100, 0, -1, 0, 0);
        xfer("wrapaddr", 0, 8, 1, 0, 32'hFFFF_FFF8, 4, -1, 0, 0);
        xfer("stall", 1, 10, 1, 1, 32'h200, 4, 1, 5, 0);
        xfer("zero", 0, 0, 1, 0, 32'h40, 4, -1, 0, 0);
        xfer("eqmax", 1, 4, 1, 0, 32'h80, 4, -1, 0, 0);
        xfer("bigmax", 1, 20, 1, 0, 32'h10, 16'hFFFF, -1, 0, 0);
        xfer("maxbig", 0, 32767, 0, 0, 32'h0, 3, -1, 0, 0);

        // reset after the first handshake of a 3-chunk transfer
        cfg_max  = 16'd4;
        in_valid = 1'b1;
        in_write = 1'b1;
        in_burst = 15'd12;
        in_type  = 1'b1;
        in_space = 1'b0;
        in_addr  = 32'h300;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("midrst.p%0d.valid", d + 1), 64'(ov[d]), 0);
            chk($sformatf("midrst.p%0d.in_ready", d + 1), 64'(in_rdy[d]), 1);
            chk($sformatf("midrst.p%0d.burst", d + 1), 64'(ob[d]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("postrst");
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle($sformatf("stale%0d", i));
        end
        out_ready = 1'b0;

        for (int i = 0; i < 40; i++) begin
            int unsigned mx;
            mx = ($urandom_range(0, 9) == 0) ? 16'hFFFF : $urandom_range(0, 9);
            xfer($sformatf("rnd%0d", i), 1'($urandom), $urandom_range(0, 40),
                 1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, mx,
                 -1, 0, 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
